fetch_align_buffer: RTL and testbench

Instruction-fetch front end for the RV32IC core, sitting directly upstream of the decode stage and driving the instruction port of the unified byte-addressed memory. It issues word-aligned 32-bit fetches, queues the returned data as halfwords, and presents one aligned instruction per handshake: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. It also tracks the PC of the presented instruction and flushes on control-flow redirects.

---
 rtl/fetch_align_buffer.sv | 186 ++++++++++++++++++
 tb/tb_fetch_align_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer
// Instruction-fetch front end for an RV32IC core. Issues word-aligned fetches,
// keeps returned data in a circular halfword queue, and presents one aligned
// instruction (16-bit compressed or 32-bit, possibly straddling a word) per
// decode handshake together with its PC. A redirect flushes the queue and
// restarts fetching at the new PC; an odd-halfword target drops the lower
// halfword of the first fetched word.
//
// state | meaning
// ------+-----------------------------------------------------------------
// BOOT  | single cycle after reset release; no fetch request is issued
// RUN   | fetch whenever the queue has room for a whole word (2 halfwords)
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH_HW = 6
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_is_c
);

    localparam int PTR_W = (DEPTH_HW > 1) ? $clog2(DEPTH_HW) : 1;
    localparam int CNT_W = $clog2(DEPTH_HW + 1);

    // A request is only allowed while two free slots remain for the whole word.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEPTH_HW - 2);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH_HW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Pointers wrap modulo DEPTH_HW, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [0:0]        state_q, state_d;
    logic [15:0]       queue_q [DEPTH_HW];
    logic [15:0]       queue_d [DEPTH_HW];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              skip_q, skip_d;
    logic [31:0]       fetch_addr_q, fetch_addr_d;
    logic [31:0]       pc_q, pc_d;

    logic [PTR_W-1:0]  head_p1, head_p2;
    logic [PTR_W-1:0]  tail_p1, tail_p2;
    logic [15:0]       hw_head, hw_next;
    logic              has_one, has_two;
    logic              head_is_c;
    logic              instr_avail;
    logic              grant;
    logic              pop;
    logic [CNT_W-1:0]  push_n, pop_n;

    // Bit 0 of a redirect target is a don't-care; halfword alignment is implied.
    logic              unused_redirect_bit0;
    assign unused_redirect_bit0 = redirect_pc[0];

    assign head_p1 = ptr_next(head_q);
    assign head_p2 = ptr_next(head_p1);
    assign tail_p1 = ptr_next(tail_q);
    assign tail_p2 = ptr_next(tail_p1);

    assign mem_addr = fetch_addr_q;
    assign instr_pc = pc_q;

    // Classify the head halfword and build the presented instruction.
    always_comb begin
        hw_head     = queue_q[head_q];
        hw_next     = queue_q[head_p1];
        has_one     = (count_q >= CNT_ONE);
        has_two     = (count_q >= CNT_TWO);
        head_is_c   = (hw_head[1:0] != 2'b11);
        // A 32-bit instruction whose upper half is not yet fetched stays invalid.
        instr_avail = (has_one && head_is_c) || has_two;
        instr_valid = instr_avail && !redirect;
        instr_is_c  = has_one && head_is_c;
        if (!has_one) begin
            instr = '0;
        end else if (head_is_c) begin
            instr = {16'h0000, hw_head};
        end else begin
            instr = {hw_next, hw_head};
        end
    end

    // Fetch request and the push/pop amounts for this cycle.
    always_comb begin
        mem_req = (state_q == ST_RUN) && (count_q <= CNT_LIMIT) && !redirect;
        grant   = mem_req && mem_gnt;
        pop     = instr_valid && instr_ready;
        push_n  = '0;
        pop_n   = '0;
        if (grant) begin
            push_n = skip_q ? CNT_ONE : CNT_TWO;
        end
        if (pop) begin
            pop_n = head_is_c ? CNT_ONE : CNT_TWO;
        end
    end

    // Next-state logic: redirect flushes everything, otherwise push and pop.
    always_comb begin
        state_d      = ST_RUN;
        queue_d      = queue_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        skip_d       = skip_q;
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;

        if (redirect) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            skip_d       = redirect_pc[1];
            fetch_addr_d = {redirect_pc[31:2], 2'b00};
            pc_d         = {redirect_pc[31:1], 1'b0};
        end else begin
            if (grant) begin
                if (skip_q) begin
                    // Odd-halfword target: only the upper halfword is wanted.
                    queue_d[tail_q] = mem_rdata[31:16];
                    tail_d          = tail_p1;
                end else begin
                    queue_d[tail_q]  = mem_rdata[15:0];
                    queue_d[tail_p1] = mem_rdata[31:16];
                    tail_d           = tail_p2;
                end
                skip_d       = 1'b0;
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            if (pop) begin
                if (head_is_c) begin
                    head_d = head_p1;
                    pc_d   = pc_q + 32'd2;
                end else begin
                    head_d = head_p2;
                    pc_d   = pc_q + 32'd4;
                end
            end
            count_d = count_q + push_n - pop_n;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            for (int i = 0; i < DEPTH_HW; i++) begin
                queue_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            skip_q       <= RESET_PC[1];
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            pc_q         <= {RESET_PC[31:1], 1'b0};
        end else begin
            state_q      <= state_d;
            queue_q      <= queue_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            skip_q       <= skip_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Testbench for fetch_align_buffer: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// halfword-queue reference model.
module tb_fetch_align_buffer;

    localparam int DEPTH = 6;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_c;

    fetch_align_buffer #(.RESET_PC(32'h0000_0000), .DEPTH_HW(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_is_c  (instr_is_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    logic [31:0] mem_tbl [256];

    // reference model state
    logic [15:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_faddr;
    bit          m_skip;
    bit          m_run;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc_n, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        chk(nm, {31'b0, got}, {31'b0, exp});
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem_tbl[i] = $urandom;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_tbl[a[9:2]];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_faddr = 32'h0;
        m_skip  = 1'b0;
        m_run   = 1'b0;
    endtask

    // What the outputs must be from the current model contents and inputs.
    task automatic model_out(output bit req, output bit vld, output bit is_c,
                             output logic [31:0] ins);
        int n;
        n    = mq.size();
        is_c = 1'b0;
        ins  = 32'h0;
        if (n >= 1) begin
            is_c = (mq[0][1:0] != 2'b11);
            ins  = is_c ? {16'h0, mq[0]} : 32'h0;
        end
        if (n >= 2 && !is_c) ins = {mq[1], mq[0]};
        vld = !redirect && ((n >= 1 && is_c) || n >= 2);
        req = m_run && (n <= DEPTH - 2) && !redirect;
    endtask

    task automatic compare();
        bit r, v, c;
        logic [31:0] ins;
        model_out(r, v, c, ins);
        chk1("mem_req", mem_req, r);
        chk("mem_addr", mem_addr, m_faddr);
        chk1("instr_valid", instr_valid, v);
        chk("instr_pc", instr_pc, m_pc);
        if (v) begin
            chk("instr", instr, ins);
            chk1("instr_is_c", instr_is_c, c);
        end
    endtask

    task automatic model_update();
        bit r, v, c;
        logic [31:0] ins;
        model_out(r, v, c, ins);
        if (redirect) begin
            mq.delete();
            m_faddr = {redirect_pc[31:2], 2'b00};
            m_skip  = redirect_pc[1];
            m_pc    = {redirect_pc[31:1], 1'b0};
        end else begin
            if (v && instr_ready) begin
                void'(mq.pop_front());
                if (!c) void'(mq.pop_front());
                m_pc = m_pc + (c ? 32'd2 : 32'd4);
            end
            if (r && mem_gnt) begin
                if (!m_skip) mq.push_back(mem_rdata[15:0]);
                mq.push_back(mem_rdata[31:16]);
                m_skip  = 1'b0;
                m_faddr = m_faddr + 32'd4;
            end
        end
        m_run = 1'b1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_gnt     = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        mem_rdata = mem_word(m_faddr);
        cyc_n++;
        #1 compare();
    endtask

    task automatic cyc(input bit gnt, input bit rdy, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc_n++;
        mem_gnt     = gnt;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        mem_rdata   = mem_word(m_faddr);
        #1 compare();
    endtask

    task automatic chk_reset_values();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk1("rst_instr_is_c", instr_is_c, 1'b0);
        chk("rst_instr_pc", instr_pc, 32'h0);
    endtask

    initial begin
        rst         = 1'b0;
        mem_gnt     = 1'b0;
        mem_rdata   = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        model_reset();
        fill_mem();
        repeat (2) @(posedge clk);
        #1 chk_reset_values();

        // boot sequence
        mem_tbl[0] = 32'h0041_0113;
        do_reset();
        chk1("boot_no_req", mem_req, 1'b0);
        cyc(1, 1, 0, 0);
        chk1("boot_req", mem_req, 1'b1);
        chk("boot_addr", mem_addr, 32'h0);
        cyc(0, 1, 0, 0);
        chk1("boot_valid", instr_valid, 1'b1);
        chk("boot_instr", instr, 32'h0041_0113);
        chk("boot_pc", instr_pc, 32'h0);
        chk1("boot_is_c", instr_is_c, 1'b0);

        // compressed pair
        fill_mem();
        mem_tbl[0] = 32'h4505_0505;
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("cpair_instr0", instr, 32'h0000_0505);
        chk("cpair_pc0", instr_pc, 32'h0);
        chk1("cpair_c0", instr_is_c, 1'b1);
        cyc(0, 1, 0, 0);
        chk("cpair_instr1", instr, 32'h0000_4505);
        chk("cpair_pc1", instr_pc, 32'h2);
        chk1("cpair_c1", instr_is_c, 1'b1);

        // straddling 32-bit instruction
        fill_mem();
        mem_tbl[0] = 32'h0113_0505;
        mem_tbl[1] = 32'h1111_0041;
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("strad_c_instr", instr, 32'h0000_0505);
        chk1("strad_c_valid", instr_valid, 1'b1);
        cyc(0, 1, 0, 0);
        chk1("strad_wait0", instr_valid, 1'b0);
        cyc(1, 1, 0, 0);
        chk1("strad_wait1", instr_valid, 1'b0);
        chk("strad_addr", mem_addr, 32'h4);
        cyc(0, 1, 0, 0);
        chk1("strad_valid", instr_valid, 1'b1);
        chk("strad_instr", instr, 32'h0041_0113);
        chk("strad_pc", instr_pc, 32'h2);
        cyc(0, 1, 0, 0);
        chk("strad_next_instr", instr, 32'h0000_1111);
        chk("strad_next_pc", instr_pc, 32'h6);

        // odd redirect
        fill_mem();
        mem_tbl[64] = 32'h5552_7777;
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 32'h0000_0102);
        chk1("redir_valid", instr_valid, 1'b0);
        chk1("redir_req", mem_req, 1'b0);
        cyc(1, 1, 0, 0);
        chk1("redir_next_req", mem_req, 1'b1);
        chk("redir_next_addr", mem_addr, 32'h100);
        cyc(0, 1, 0, 0);
        chk1("redir_first_valid", instr_valid, 1'b1);
        chk("redir_first_pc", instr_pc, 32'h102);
        chk("redir_first_instr", instr, 32'h0000_5552);

        // back-pressure, then reset mid-operation
        fill_mem();
        mem_tbl[0] = 32'h0041_0113;
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk1("bp_full_req", mem_req, 1'b0);
        cyc(1, 1, 0, 0);
        chk("bp_pop_instr", instr, 32'h0041_0113);
        chk1("bp_pop_req", mem_req, 1'b0);
        cyc(1, 0, 0, 0);
        chk1("bp_rereq", mem_req, 1'b1);
        chk("bp_rereq_addr", mem_addr, 32'hC);
        chk1("midrst_pre_valid", instr_valid, 1'b1);
        rst = 1'b0;
        #1 chk_reset_values();
        do_reset();
        cyc(1, 1, 0, 0);
        chk1("midrst_restart_req", mem_req, 1'b1);
        chk("midrst_restart_addr", mem_addr, 32'h0);

        // randomized run against the model
        fill_mem();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            bit rd;
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hE))
                                               : ($urandom & 32'h0000_03FE);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rd, rpc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
